div_mult_unit: RTL and testbench

DIV_MULT_UNIT -- requirements
Module: div_mult_unit

---
 rtl/div_mult_unit.sv | 133 +++++++++++++
 tb/tb_div_mult_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/div_mult_unit.sv
// div_mult_unit: signed 32x32 multiply (shift-add) and divide (restoring), one iteration per clock.
// Optional macro DIV_MULT_FAST_ZERO_EN: a MULT with a zero operand completes without iterating.
module div_mult_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div0
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      state, state_next;
  logic [5:0]  count;
  logic        is_div, sign_a, sign_b;
  logic [31:0] acc_hi, acc_lo, opnd;
  logic        div_by_zero, fast_zero, launch;
  logic        busy_next, done_next, div0_next;
  logic [32:0] mult_sum, div_shift;
  logic [31:0] div_diff;
  logic        div_fits;
  logic [63:0] prod_mag, prod_signed;
  logic [31:0] quot, rem;

  assign div_by_zero = op_div && (b == '0);
`ifdef DIV_MULT_FAST_ZERO_EN
  assign fast_zero = !op_div && ((a == '0) || (b == '0));
`else
  assign fast_zero = 1'b0;
`endif
  assign launch = (state == IDLE) && start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (div_by_zero || fast_zero) ? DONE : RUN;
      RUN:     if (count == 6'd31) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output values are decoded from the next state so the flops below present them registered.
  always_comb begin
    busy_next = (state_next == RUN) || (state_next == FIX);
    done_next = (state_next == DONE);
    div0_next = launch && div_by_zero;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      div0 <= 1'b0;
    end else begin
      busy <= busy_next;
      done <= done_next;
      div0 <= div0_next;
    end
  end

  // Magnitude iteration: MULT shifts the product right through acc_lo,
  // DIV shifts the dividend left out of acc_lo into the partial remainder acc_hi.
  always_comb begin
    mult_sum    = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : 32'd0)};
    div_shift   = {acc_hi, acc_lo[31]};
    div_fits    = div_shift >= {1'b0, opnd};
    div_diff    = div_shift[31:0] - opnd;
    prod_mag    = {acc_hi, acc_lo};
    prod_signed = (sign_a ^ sign_b) ? -prod_mag : prod_mag;
    quot        = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
    rem         = sign_a ? -acc_hi : acc_hi;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      is_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          is_div <= op_div;
          sign_a <= a[31];
          sign_b <= b[31];
          acc_hi <= '0;
          acc_lo <= a[31] ? -a : a;
          opnd   <= b[31] ? -b : b;
          count  <= '0;
          if (fast_zero) begin
            hi <= '0;
            lo <= '0;
          end
        end
        RUN: begin
          count <= count + 6'd1;
          if (is_div) begin
            acc_hi <= div_fits ? div_diff : div_shift[31:0];
            acc_lo <= {acc_lo[30:0], div_fits};
          end else begin
            acc_hi <= mult_sum[32:1];
            acc_lo <= {mult_sum[0], acc_lo[31:1]};
          end
        end
        FIX: begin
          if (is_div) {hi, lo} <= {rem, quot};
          else        {hi, lo} <= prod_signed;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_mult_unit.sv
// tb_div_mult_unit: directed and random MULT/DIV operations against a signed-arithmetic reference model.
module tb_div_mult_unit;

  logic        clk = 1'b0;
  logic        reset, start, op_div;
  logic [31:0] a, b, hi, lo;
  logic        busy, done, div0;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  always #5 clk = ~clk;

  div_mult_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op_div(op_div),
    .a     (a),
    .b     (b),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done),
    .div0  (div0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed 64-bit arithmetic; '/' truncates toward zero and '%' follows the dividend.
  function automatic void model_op(input bit is_div, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] e_hi, output logic [31:0] e_lo, output bit e_div0);
    longint sx, sy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e_div0 = 1'b0;
    if (is_div && y == 32'd0) begin
      e_hi = model_hi;
      e_lo = model_lo;
      e_div0 = 1'b1;
    end else if (is_div) begin
      q = sx / sy;
      r = sx % sy;
      e_lo = q[31:0];
      e_hi = r[31:0];
    end else begin
      p = sx * sy;
      e_hi = p[63:32];
      e_lo = p[31:0];
    end
  endfunction

  // Cycles after E0 at which done is expected.
  function automatic int exp_latency(input bit is_div, input logic [31:0] x, input logic [31:0] y);
    if (is_div && y == 32'd0) return 0;
`ifdef DIV_MULT_FAST_ZERO_EN
    if (!is_div && (x == 32'd0 || y == 32'd0)) return 0;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 1000)) - 32'd500;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input string tag, input bit is_div, input logic [31:0] x, input logic [31:0] y,
                        input bit hold_start, input bit release_reset);
    logic [31:0] e_hi, e_lo;
    bit          e_div0, wait_ok;
    int          lat, n;
    model_op(is_div, x, y, e_hi, e_lo, e_div0);
    lat = exp_latency(is_div, x, y);
    @(negedge clk);
    start = 1'b1; op_div = is_div; a = x; b = y;
    if (release_reset) reset = 1'b0;
    @(posedge clk);  // E0
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    n = 0;
    wait_ok = 1'b1;
    while (done !== 1'b1 && n < 40) begin
      if (busy !== 1'b1 || div0 !== 1'b0) wait_ok = 1'b0;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "/latency"}, 64'(n), 64'(lat));
    check({tag, "/wait_busy"}, 64'(wait_ok), 64'd1);
    check({tag, "/done_busy"}, 64'(busy), 64'd0);
    check({tag, "/div0"}, 64'(div0), 64'(e_div0));
    check({tag, "/result"}, {hi, lo}, {e_hi, e_lo});
    model_hi = e_hi;
    model_lo = e_lo;
    @(negedge clk);
    check({tag, "/after"}, {hi, lo, 29'd0, busy, done, div0}, {e_hi, e_lo, 32'd0});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op_div = 1'b0; a = '0; b = '0;
    #1;
    check("reset_async", {hi, lo, 29'd0, busy, done, div0}, 64'd0 << 0);
    start = 1'b1; op_div = 1'b0; a = 32'd3; b = 32'd4;
    repeat (3) @(negedge clk);
    check("reset_held", {hi, lo, 29'd0, busy, done, div0}, 64'd0);
    start = 1'b0;
    reset = 1'b0;

    run_op("mul_7_m3",   1'b0, 32'd7,          32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("div_m7_2",   1'b1, 32'hFFFF_FFF9,  32'd2,         1'b0, 1'b0);
    run_op("mul_3_5",    1'b0, 32'd3,          32'd5,         1'b0, 1'b0);
    run_op("div_by_0",   1'b1, 32'd100,        32'd0,         1'b0, 1'b0);
    run_op("div_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("mul_0_9",    1'b0, 32'd0,          32'd9,         1'b0, 1'b0);
    run_op("div_m9_m4",  1'b1, 32'hFFFF_FFF7,  32'hFFFF_FFFC, 1'b0, 1'b0);

    // Abort a long MULT with an asynchronous reset partway through RUN.
    @(negedge clk);
    start = 1'b1; op_div = 1'b0; a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1 check("abort_async", {hi, lo, 29'd0, busy, done, div0}, 64'd0);
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    n_wait_no_done();
    run_op("mul_max",    1'b0, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 1'b0, 1'b0);

    // Start already high when reset releases must be taken at the first edge.
    @(negedge clk);
    reset = 1'b1;
    model_hi = '0;
    model_lo = '0;
    run_op("rst_release", 1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 1'b0, 1'b1);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] x, y;
      bit          d;
      x = rand_operand();
      y = rand_operand();
      d = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", i), d, x, y, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // After an aborted operation, no done pulse may appear while idle.
  task automatic n_wait_no_done();
    bit seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    check("abort_no_done", 64'(seen), 64'd0);
  endtask

endmodule
